// File: rtl/micro_mac_driver.sv
// micro_mac_driver: steps the micro_mac inputs x1..x3 through a binary count
// and samples the machine output once per step. Each sample is folded into a
// CRC-style signature and a ones-count. On completion the block flags
// pass/fail against an expected signature.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_IDLE | waiting for i_start, outputs quiet
// S_RUN  | stepping stimulus, one sample on last clock of each step
// S_DONE | run finished, o_sig/o_ones/o_pass held until next start
module micro_mac_driver #(
    parameter int unsigned DIV      = 2,
    parameter int unsigned STEPS    = 16,
    parameter logic [15:0] SIG_INIT = 16'h0000,
    parameter logic [15:0] POLY     = 16'h1021,
    parameter logic [15:0] EXP_SIG  = 16'h0000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_out,
    output logic        o_x1,
    output logic        o_x2,
    output logic        o_x3,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_sig,
    output logic [15:0] o_ones
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0]  LAST_PRE  = 8'(DIV - 1);
    localparam logic [15:0] LAST_STEP = 16'(STEPS - 1);

    state_t      state_q, state_d;
    logic [15:0] step_q, step_d;
    logic [7:0]  pre_q, pre_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] ones_q, ones_d;
    logic        pass_q, pass_d;
    logic [2:0]  x_q, x_d;
    logic        fb;
    logic [15:0] sig_next;

    // Signature value that results if the current clock is a sampling clock.
    always_comb begin
        fb       = sig_q[15] ^ i_out;
        sig_next = {sig_q[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
    end

    // Next-state and datapath updates; start from IDLE and DONE are identical.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        pre_d   = pre_q;
        sig_d   = sig_q;
        ones_d  = ones_q;
        pass_d  = pass_q;
        x_d     = x_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    state_d = S_RUN;
                    step_d  = 16'd0;
                    pre_d   = 8'd0;
                    sig_d   = SIG_INIT;
                    ones_d  = 16'd0;
                    pass_d  = 1'b0;
                    x_d     = 3'd0;
                end
            end
            S_RUN: begin
                if (pre_q == LAST_PRE) begin
                    pre_d = 8'd0;
                    sig_d = sig_next;
                    if (i_out && (ones_q != 16'hFFFF)) begin
                        ones_d = ones_q + 16'd1;
                    end
                    if (step_q == LAST_STEP) begin
                        state_d = S_DONE;
                        pass_d  = (sig_next == EXP_SIG);
                        x_d     = 3'd0;
                    end else begin
                        step_d = step_q + 16'd1;
                        x_d    = step_q[2:0] + 3'd1;
                    end
                end else begin
                    pre_d = pre_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            step_q  <= 16'd0;
            pre_q   <= 8'd0;
            sig_q   <= SIG_INIT;
            ones_q  <= 16'd0;
            pass_q  <= 1'b0;
            x_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            pre_q   <= pre_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
            x_q     <= x_d;
        end
    end

    assign o_x1   = x_q[0];
    assign o_x2   = x_q[1];
    assign o_x3   = x_q[2];
    assign o_busy = (state_q == S_RUN);
    assign o_done = (state_q == S_DONE);
    assign o_pass = pass_q;
    assign o_sig  = sig_q;
    assign o_ones = ones_q;

endmodule

// File: doc/micro_mac_driver.md
Name: micro_mac_driver

Overview:
Synthesizable stimulus/response end of the micro_mac interface. It drives the machine inputs x1, x2 and x3 through a binary step sequence and samples the machine output once per step. The sampled bits are compacted into a CRC-style signature plus a ones-count, and the block flags pass/fail against an expected signature. It sits beside micro_mac on the board or in the bench top, so self-test runs without a simulator-only bench.

Parameters:
DIV, 2, clocks per stimulus step (legal 1..255)
STEPS, 16, number of steps per run (legal 1..65535)
SIG_INIT, 16'h0000, signature value loaded at run start
POLY, 16'h1021, signature feedback polynomial
EXP_SIG, 16'h0000, expected final signature for o_pass

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst_n  in  1  synchronous active-low reset
i_start  in  1  start request, sampled each clock
i_out  in  1  micro_mac output under test
o_x1  out  1  machine input x1 = step[0]
o_x2  out  1  machine input x2 = step[1]
o_x3  out  1  machine input x3 = step[2]
o_busy  out  1  high while in RUN
o_done  out  1  high while in DONE
o_pass  out  1  valid when o_done; 1 if o_sig == EXP_SIG
o_sig  out  16  running/final signature
o_ones  out  16  count of sampled i_out == 1

Behaviour:
- One clock is i_clk. Reset is synchronous and active-low on i_rst_n. While i_rst_n=0 at a rising edge: state=IDLE; all outputs 0; o_sig=SIG_INIT; step=0; prescaler=0. Reset mid-run aborts immediately, with no done and no partial result kept.
- FSM states:
  - IDLE: i_start=1 -> RUN next clock; clear step, prescaler and o_ones; load o_sig=SIG_INIT.
  - RUN: o_busy=1. The prescaler counts 0..DIV-1. Each step holds for exactly DIV clocks.
  - On the edge where prescaler==DIV-1: sample i_out, update o_sig and o_ones, reset the prescaler, and increment step.
  - If that sample ends step STEPS-1, go to DONE instead of incrementing.
  - DONE: o_done=1, o_busy=0. o_pass is registered as (o_sig==EXP_SIG) on entry. x outputs return to 0.
  - DONE with i_start=1 -> restart exactly as from IDLE. DONE with no start holds indefinitely.
- i_start in RUN is ignored.
- Stimulus: {o_x3,o_x2,o_x1} = step[2:0], registered. The value is 0 in the first RUN clock and wraps modulo 8 when STEPS>8. x1 toggles every DIV clocks, x2 every 2*DIV, x3 every 4*DIV.
- Signature update:
  - fb = o_sig[15] ^ i_out.
  - o_sig <= {o_sig[14:0],1'b0} ^ (fb ? POLY : 16'h0).
- o_ones saturates at 16'hFFFF and does not wrap.
- Run length: RUN lasts exactly STEPS*DIV clocks, from the first clock with o_busy=1 to the last. o_done rises on the following clock.
- i_out is sampled only on the final clock of each step. Values on other clocks have no effect.
- DIV=1: the sample occurs every clock and x changes every clock.
- Simultaneous reset and start: reset wins.

Test Plan:
- Reset: hold i_rst_n=0 for 3 clocks with i_start=1 -> all outputs 0, o_sig=0000, state IDLE; release -> still IDLE until i_start is sampled high.
- DIV=2, STEPS=8, i_out=0: pulse i_start -> o_busy high 16 clocks; {x3,x2,x1} goes 0,0,1,1,...,7,7; then o_done=1, o_sig=0000, o_ones=0, o_pass=1.
- STEPS=1, DIV=1, i_out=1 -> after 1 RUN clock o_sig=1021, o_ones=1, o_pass=0 (EXP_SIG=0000).
- DIV=3, STEPS=16, i_out=1 held -> o_busy 48 clocks, o_ones=16. x pattern is 0..7 twice, each value held 3 clocks.
- Sampling point: DIV=4, STEPS=4, i_out=1 only on prescaler values 0..2 (0 on the final clock of each step) -> o_ones=0, o_sig=0000.
- Reset at RUN clock 5 of an 8x2 run -> next clock IDLE with all outputs 0. i_start mid-run is ignored: the run length is unchanged. i_start in DONE starts a fresh run with o_ones cleared.
